shift_unit_pipe: RTL

Parametrised, optionally pipelined shift/rotate unit for the execute stage. It generalises the fixed 32-bit arithmetic right shifter to:
- any power-of-two width;
- five operations (SLL, SRL, SRA, ROR, ROL);
- a valid/ready handshake with backpressure and flush;
- a user tag carried alongside each result.

It sits between the ALU operand mux and the writeback arbiter.

---
 rtl/shift_unit_pipe.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/shift_unit_pipe.sv
// Parametrised shift/rotate unit (SLL/SRL/SRA/ROR/ROL) with valid/ready, flush and tag sideband.
// Define SHIFT_UNIT_ROTATE_EN to build ROR/ROL; otherwise ops 011/100 come back as illegal.
module shift_stage #(
  parameter int W = 32,
  parameter int S = 1
) (
  input  logic [W-1:0] d,
  input  logic         en,
  input  logic         wrap,
  input  logic         fill,
  input  logic         rev,
  output logic [W-1:0] q
);
  logic [W-1:0] t, r;
  always_comb begin
    t = d;
    if (en) t = wrap ? {d[S-1:0], d[W-1:S]} : {{S{fill}}, d[W-1:S]};
    for (int i = 0; i < W; i++) r[i] = t[W-1-i];
    q = rev ? r : t;
  end
endmodule

module shift_unit_pipe #(
  parameter int WIDTH     = 32,
  parameter int SHAMT_W   = $clog2(WIDTH),
  parameter int TAG_W     = 5,
  parameter bit PIPELINED = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [2:0]         i_op,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [TAG_W-1:0]   i_tag,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WIDTH-1:0]   o_data,
  output logic [TAG_W-1:0]   o_tag,
  output logic               o_illegal
);
  localparam int STAGES = SHAMT_W;
  localparam int NREG   = PIPELINED ? STAGES : 1;
  localparam int LAST   = STAGES - 1;
  localparam logic [2:0] OP_SLL = 3'd0, OP_SRA = 3'd2, OP_ROL = 3'd4;
`ifdef SHIFT_UNIT_ROTATE_EN
  localparam logic [2:0] OP_ROR = 3'd3;
`endif

  // Input decode: left ops are mirrored so every stage only shifts right.
  logic               e_ill, e_left;
  logic [WIDTH-1:0]   e_rev, e_dat;
  logic [SHAMT_W-1:0] e_sh;
  always_comb begin
`ifdef SHIFT_UNIT_ROTATE_EN
    e_ill = (i_op > OP_ROL);
`else
    e_ill = (i_op > OP_SRA);
`endif
    e_left = !e_ill && (i_op == OP_SLL || i_op == OP_ROL);
    for (int i = 0; i < WIDTH; i++) e_rev[i] = i_data[WIDTH-1-i];
    e_dat = e_left ? e_rev : i_data;
    e_sh  = e_ill ? '0 : i_shamt;
  end

  logic [NREG-1:0]                vld_pipe, ld, nx_v;
  logic [NREG-1:0][WIDTH-1:0]     r_dat;
  logic [NREG-1:0][2:0]           r_op;
  logic [NREG-1:0]                r_fill, r_ill;
  logic [NREG-1:0][SHAMT_W-1:0]   r_sh;
  logic [NREG-1:0][TAG_W-1:0]     r_tag;
  logic                           rdy_q;

  logic [STAGES-1:0][WIDTH-1:0]   s_dat, s_out;
  logic [STAGES-1:0][2:0]         s_op;
  logic [STAGES-1:0][SHAMT_W-1:0] s_sh;
  logic [STAGES-1:0][TAG_W-1:0]   s_tag;
  logic [STAGES-1:0]              s_fill, s_ill, s_wrap, s_rev, s_fb;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0 || !PIPELINED) begin : g_ent
      assign s_op[k]   = i_op;
      assign s_fill[k] = i_data[WIDTH-1];
      assign s_ill[k]  = e_ill;
      assign s_sh[k]   = e_sh;
      assign s_tag[k]  = i_tag;
    end else begin : g_reg
      assign s_op[k]   = r_op[k-1];
      assign s_fill[k] = r_fill[k-1];
      assign s_ill[k]  = r_ill[k-1];
      assign s_sh[k]   = r_sh[k-1];
      assign s_tag[k]  = r_tag[k-1];
    end
    if (k == 0) begin : g_d0
      assign s_dat[k] = e_dat;
    end else if (PIPELINED) begin : g_dp
      assign s_dat[k] = r_dat[k-1];
    end else begin : g_dc
      assign s_dat[k] = s_out[k-1];
    end
`ifdef SHIFT_UNIT_ROTATE_EN
    assign s_wrap[k] = !s_ill[k] && (s_op[k] == OP_ROR || s_op[k] == OP_ROL);
`else
    assign s_wrap[k] = 1'b0;
`endif
    // Mirror back after the final stage so left ops come out in natural order.
    assign s_rev[k] = (k == LAST) && !s_ill[k] && (s_op[k] == OP_SLL || s_op[k] == OP_ROL);
    assign s_fb[k]  = (s_op[k] == OP_SRA) && s_fill[k];

    shift_stage #(.W(WIDTH), .S(1 << k)) u_stage (
      .d(s_dat[k]), .en(s_sh[k][k]), .wrap(s_wrap[k]), .fill(s_fb[k]),
      .rev(s_rev[k]), .q(s_out[k])
    );
  end

  // A register may load when empty or when its content moves on this cycle.
  always_comb begin
    ld = '0;
    ld[NREG-1] = !vld_pipe[NREG-1] || i_ready;
    for (int j = NREG - 2; j >= 0; j--) ld[j] = !vld_pipe[j] || ld[j+1];
    nx_v = '0;
    nx_v[0] = i_valid && o_ready;
    for (int j = 1; j < NREG; j++) nx_v[j] = vld_pipe[j-1];
  end

  assign o_ready = rdy_q && ld[0] && !i_flush;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rdy_q    <= 1'b0;
      vld_pipe <= '0;
      r_dat    <= '0;
      r_op     <= '0;
      r_fill   <= '0;
      r_ill    <= '0;
      r_sh     <= '0;
      r_tag    <= '0;
    end else begin
      rdy_q <= 1'b1;
      for (int j = 0; j < NREG; j++) begin
        if (i_flush) begin
          vld_pipe[j] <= 1'b0;
        end else if (ld[j]) begin
          vld_pipe[j] <= nx_v[j];
          if (nx_v[j]) begin
            r_dat[j]  <= s_out[PIPELINED ? j : LAST];
            r_op[j]   <= s_op[PIPELINED ? j : LAST];
            r_fill[j] <= s_fill[PIPELINED ? j : LAST];
            r_ill[j]  <= s_ill[PIPELINED ? j : LAST];
            r_sh[j]   <= s_sh[PIPELINED ? j : LAST];
            r_tag[j]  <= s_tag[PIPELINED ? j : LAST];
          end
        end
      end
    end
  end

  assign o_valid   = vld_pipe[NREG-1];
  assign o_data    = r_dat[NREG-1];
  assign o_tag     = r_tag[NREG-1];
  assign o_illegal = r_ill[NREG-1];
endmodule
